store_buffer: RTL and testbench

Store-side counterpart of the load data generator in the pipelined core. Accepts store requests from the MEM stage (address, rs2 data, size select), converts them to word-aligned lane data plus a byte mask, and queues them in a DEPTH-entry FIFO. Entries drain to data memory over a valid/ready port. A word-address hazard flag lets the hazard unit stall younger loads that hit a pending store.

---
 rtl/store_pkg.sv | 14 +
 rtl/store_align.sv | 37 +++
 rtl/store_buffer.sv | 107 ++++++++++
 tb/tb_store_buffer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_pkg.sv
// Shared types and size-select encodings for the store path.
package store_pkg;

  localparam logic [2:0] SEL_SB = 3'b001;
  localparam logic [2:0] SEL_SH = 3'b010;
  localparam logic [2:0] SEL_SW = 3'b011;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bmask;
  } st_entry_t;

endpackage

// File: rtl/store_align.sv
// Converts a store request into word-lane data and byte enables; flags bad size/alignment.
module store_align
  import store_pkg::*;
(
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_data,
  input  logic [2:0]  i_sel,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_bmask,
  output logic        o_err
);

  always_comb begin
    o_wdata = i_data;
    o_bmask = 4'b0000;
    o_err   = 1'b1;
    case (i_sel)
      SEL_SB: begin
        o_wdata = {4{i_data[7:0]}};
        o_bmask = 4'b0001 << i_addr;
        o_err   = 1'b0;
      end
      SEL_SH: begin
        o_wdata = {2{i_data[15:0]}};
        o_bmask = i_addr[1] ? 4'b1100 : 4'b0011;
        o_err   = i_addr[0];
      end
      SEL_SW: begin
        o_wdata = i_data;
        o_bmask = 4'b1111;
        o_err   = |i_addr;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// DEPTH-entry store FIFO between MEM stage and data memory, with a word-address load hazard flag.
module store_buffer
  import store_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_st_valid,
  output logic                       o_st_ready,
  input  logic [31:0]                i_st_addr,
  input  logic [31:0]                i_st_data,
  input  logic [2:0]                 i_sl_sel,
  output logic                       o_st_err,
  output logic                       o_mem_valid,
  input  logic                       i_mem_ready,
  output logic [31:0]                o_mem_addr,
  output logic [31:0]                o_mem_wdata,
  output logic [3:0]                 o_mem_bmask,
  input  logic [31:0]                i_fwd_addr,
  output logic                       o_fwd_hazard,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  st_entry_t       r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_st_err;

  logic [31:0]     w_wdata;
  logic [3:0]      w_bmask;
  logic            w_align_err;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  st_entry_t       w_head;
  logic [PW-1:0]   w_idx;
  logic [PW-1:0]   w_off;

  store_align u_align (
    .i_addr  (i_st_addr[1:0]),
    .i_data  (i_st_data),
    .i_sel   (i_sl_sel),
    .o_wdata (w_wdata),
    .o_bmask (w_bmask),
    .o_err   (w_align_err)
  );

  assign o_st_ready  = r_count < CW'(DEPTH);
  assign o_mem_valid = r_count != '0;
  assign o_empty     = r_count == '0;
  assign o_count     = r_count;
  assign o_st_err    = r_st_err;

  assign w_accept = i_st_valid && o_st_ready;
  assign w_push   = w_accept && !w_align_err;
  assign w_pop    = o_mem_valid && i_mem_ready;

  assign w_head      = r_mem[r_rd_ptr];
  assign o_mem_addr  = {w_head.addr, 2'b00};
  assign o_mem_wdata = w_head.wdata;
  assign o_mem_bmask = w_head.bmask;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_st_err <= 1'b0;
    end else begin
      r_st_err <= w_accept && w_align_err;
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_reset) begin
      r_mem[r_wr_ptr] <= '{addr: i_st_addr[31:2], wdata: w_wdata, bmask: w_bmask};
    end
  end

  // A slot is live when its distance from the read pointer is below the occupancy count.
  always_comb begin
    o_fwd_hazard = 1'b0;
    w_idx        = '0;
    w_off        = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_idx = PW'(i);
      w_off = w_idx - r_rd_ptr;
      if ((CW'(w_off) < r_count) && (r_mem[w_idx].addr == i_fwd_addr[31:2])) begin
        o_fwd_hazard = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: align table, directed corner sequences, random vs queue model.
module tb_store_buffer;

  logic        i_clk;
  logic        i_reset;
  logic        i_st_valid;
  logic        o_st_ready;
  logic [31:0] i_st_addr;
  logic [31:0] i_st_data;
  logic [2:0]  i_sl_sel;
  logic        o_st_err;
  logic        o_mem_valid;
  logic        i_mem_ready;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_bmask;
  logic [31:0] i_fwd_addr;
  logic        o_fwd_hazard;
  logic [2:0]  o_count;
  logic        o_empty;

  int n_vec = 0;
  int n_err = 0;

  store_buffer #(.DEPTH(4)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_st_valid   (i_st_valid),
    .o_st_ready   (o_st_ready),
    .i_st_addr    (i_st_addr),
    .i_st_data    (i_st_data),
    .i_sl_sel     (i_sl_sel),
    .o_st_err     (o_st_err),
    .o_mem_valid  (o_mem_valid),
    .i_mem_ready  (i_mem_ready),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_bmask  (o_mem_bmask),
    .i_fwd_addr   (i_fwd_addr),
    .o_fwd_hazard (o_fwd_hazard),
    .o_count      (o_count),
    .o_empty      (o_empty)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  sel;
    logic        err;
    logic [31:0] wdata;
    logic [3:0]  bmask;
  } vec_t;

  typedef struct {
    logic [29:0] word;
    logic [31:0] wdata;
    logic [3:0]  bmask;
  } ment_t;

  vec_t  vecs [12];
  ment_t mq [$];
  logic [31:0] aq [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_st_valid  = 1'b0;
    i_mem_ready = 1'b0;
    i_reset     = 1'b1;
    tick();
    i_reset     = 1'b0;
  endtask

  task automatic push(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] sel);
    i_st_valid = 1'b1;
    i_st_addr  = addr;
    i_st_data  = data;
    i_sl_sel   = sel;
    tick();
    i_st_valid = 1'b0;
  endtask

  // Reference alignment from the lane rules, using plain arithmetic.
  function automatic void model_align(input logic [31:0] addr, input logic [31:0] data,
                                      input logic [2:0] sel, output logic bad,
                                      output logic [31:0] wd, output logic [3:0] bm);
    int a;
    a   = int'(addr % 4);
    bad = 1'b1;
    wd  = 32'h0;
    bm  = 4'h0;
    case (sel)
      3'd1: begin bad = 1'b0; wd = 32'(data[7:0]) * 32'h01010101; bm = 4'(1 << a); end
      3'd2: begin bad = (a % 2) != 0; wd = 32'(data[15:0]) * 32'h00010001; bm = 4'(3 << a); end
      3'd3: begin bad = (a != 0); wd = data; bm = 4'hF; end
      default: ;
    endcase
  endfunction

  initial begin
    vecs[0]  = '{32'h0000_1003, 32'hAABB_CC5A, 3'b001, 1'b0, 32'h5A5A_5A5A, 4'b1000};
    vecs[1]  = '{32'h0000_1000, 32'h1122_3344, 3'b001, 1'b0, 32'h4444_4444, 4'b0001};
    vecs[2]  = '{32'h0000_1001, 32'h0000_00A5, 3'b001, 1'b0, 32'hA5A5_A5A5, 4'b0010};
    vecs[3]  = '{32'h0000_2002, 32'h1234_BEEF, 3'b010, 1'b0, 32'hBEEF_BEEF, 4'b1100};
    vecs[4]  = '{32'h0000_2000, 32'h0000_CAFE, 3'b010, 1'b0, 32'hCAFE_CAFE, 4'b0011};
    vecs[5]  = '{32'h0000_2001, 32'h1234_5678, 3'b010, 1'b1, 32'h0, 4'b0000};
    vecs[6]  = '{32'h0000_2002, 32'h1234_5678, 3'b011, 1'b1, 32'h0, 4'b0000};
    vecs[7]  = '{32'h0000_3000, 32'hDEAD_BEEF, 3'b011, 1'b0, 32'hDEAD_BEEF, 4'b1111};
    vecs[8]  = '{32'h0000_3003, 32'hDEAD_BEEF, 3'b011, 1'b1, 32'h0, 4'b0000};
    vecs[9]  = '{32'h0000_3000, 32'h0000_0011, 3'b100, 1'b1, 32'h0, 4'b0000};
    vecs[10] = '{32'h0000_3000, 32'h0000_0011, 3'b000, 1'b1, 32'h0, 4'b0000};
    vecs[11] = '{32'h0000_3000, 32'h0000_0011, 3'b111, 1'b1, 32'h0, 4'b0000};

    i_st_valid = 1'b0; i_st_addr = '0; i_st_data = '0; i_sl_sel = 3'b001;
    i_mem_ready = 1'b0; i_fwd_addr = '0; i_reset = 1'b1;
    tick();
    tick();
    i_reset = 1'b0;
    #1;
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_empty", 32'(o_empty), 32'd1);
    chk("rst_mem_valid", 32'(o_mem_valid), 32'd0);
    chk("rst_err", 32'(o_st_err), 32'd0);
    chk("rst_hazard", 32'(o_fwd_hazard), 32'd0);
    chk("rst_ready", 32'(o_st_ready), 32'd1);

    // Align table: one request into an empty buffer, inspect the head a cycle later.
    for (int k = 0; k < 12; k++) begin
      do_reset();
      push(vecs[k].addr, vecs[k].data, vecs[k].sel);
      chk($sformatf("tbl%0d_err", k), 32'(o_st_err), 32'(vecs[k].err));
      chk($sformatf("tbl%0d_count", k), 32'(o_count), vecs[k].err ? 32'd0 : 32'd1);
      if (!vecs[k].err) begin
        chk($sformatf("tbl%0d_valid", k), 32'(o_mem_valid), 32'd1);
        chk($sformatf("tbl%0d_addr", k), o_mem_addr, vecs[k].addr & 32'hFFFF_FFFC);
        chk($sformatf("tbl%0d_wdata", k), o_mem_wdata, vecs[k].wdata);
        chk($sformatf("tbl%0d_bmask", k), 32'(o_mem_bmask), 32'(vecs[k].bmask));
      end
      tick();
      chk($sformatf("tbl%0d_err_end", k), 32'(o_st_err), 32'd0);
    end

    // Fill under backpressure, refuse a fifth, then drain in order.
    do_reset();
    for (int k = 0; k < 4; k++) push(32'h10 + 32'(4 * k), 32'hA000_0000 + 32'(k), 3'b011);
    chk("full_ready", 32'(o_st_ready), 32'd0);
    chk("full_count", 32'(o_count), 32'd4);
    push(32'h20, 32'hFFFF_FFFF, 3'b011);
    chk("full_refuse_count", 32'(o_count), 32'd4);
    chk("full_refuse_err", 32'(o_st_err), 32'd0);
    i_mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("drain%0d_valid", k), 32'(o_mem_valid), 32'd1);
      chk($sformatf("drain%0d_addr", k), o_mem_addr, 32'h10 + 32'(4 * k));
      chk($sformatf("drain%0d_wdata", k), o_mem_wdata, 32'hA000_0000 + 32'(k));
      tick();
    end
    i_mem_ready = 1'b0;
    chk("drain_empty", 32'(o_empty), 32'd1);
    chk("drain_count", 32'(o_count), 32'd0);

    // Steady push+pop at count 3 across several pointer wraps.
    do_reset();
    aq.delete();
    for (int k = 0; k < 3; k++) begin
      push(32'h80 + 32'(4 * k), 32'(k), 3'b011);
      aq.push_back(32'h80 + 32'(4 * k));
    end
    for (int k = 0; k < 10; k++) begin
      i_st_valid = 1'b1; i_st_addr = 32'h100 + 32'(4 * k); i_st_data = 32'(k);
      i_sl_sel = 3'b011; i_mem_ready = 1'b1;
      #1;
      chk($sformatf("pp%0d_count", k), 32'(o_count), 32'd3);
      chk($sformatf("pp%0d_ready", k), 32'(o_st_ready), 32'd1);
      chk($sformatf("pp%0d_head", k), o_mem_addr, aq[0]);
      tick();
      void'(aq.pop_front());
      aq.push_back(32'h100 + 32'(4 * k));
    end
    i_st_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("pp_tail%0d_addr", k), o_mem_addr, aq[k]);
      tick();
    end
    i_mem_ready = 1'b0;
    chk("pp_tail_empty", 32'(o_empty), 32'd1);

    // Hazard: pending entry matches on word address only; in-flight accept not included.
    do_reset();
    push(32'h1000, 32'h55, 3'b001);
    i_fwd_addr = 32'h1002;
    #1 chk("haz_hit", 32'(o_fwd_hazard), 32'd1);
    i_fwd_addr = 32'h1004;
    #1 chk("haz_miss", 32'(o_fwd_hazard), 32'd0);
    do_reset();
    i_fwd_addr = 32'h1000;
    i_st_valid = 1'b1; i_st_addr = 32'h1000; i_sl_sel = 3'b011;
    #1 chk("haz_inflight", 32'(o_fwd_hazard), 32'd0);
    tick();
    i_st_valid = 1'b0;
    #1 chk("haz_after_push", 32'(o_fwd_hazard), 32'd1);

    // Reset while offering the head discards everything.
    do_reset();
    for (int k = 0; k < 3; k++) push(32'h40 + 32'(4 * k), 32'(k), 3'b011);
    chk("mid_count", 32'(o_count), 32'd3);
    i_mem_ready = 1'b1;
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    i_mem_ready = 1'b0;
    chk("mid_rst_count", 32'(o_count), 32'd0);
    chk("mid_rst_valid", 32'(o_mem_valid), 32'd0);
    chk("mid_rst_empty", 32'(o_empty), 32'd1);

    // Back-to-back bad requests give back-to-back pulses.
    do_reset();
    i_st_valid = 1'b1; i_st_addr = 32'h0; i_sl_sel = 3'b100;
    tick();
    chk("b2b_err0", 32'(o_st_err), 32'd1);
    i_st_addr = 32'h1; i_sl_sel = 3'b010;
    tick();
    chk("b2b_err1", 32'(o_st_err), 32'd1);
    chk("b2b_count", 32'(o_count), 32'd0);
    i_st_valid = 1'b0;
    tick();
    chk("b2b_err_end", 32'(o_st_err), 32'd0);

    // Random traffic against a queue model.
    do_reset();
    mq.delete();
    begin
      logic m_err;
      m_err = 1'b0;
      for (int c = 0; c < 3000; c++) begin
        logic        bad, hz, accept;
        logic [31:0] wd;
        logic [3:0]  bm;
        int          r;
        ment_t       e;
        i_reset     = ($urandom_range(0, 149) == 0);
        i_st_valid  = 1'($urandom_range(0, 1));
        r           = int'($urandom_range(0, 9));
        i_sl_sel    = (r < 3) ? 3'd1 : (r < 6) ? 3'd2 : (r < 8) ? 3'd3 : 3'($urandom_range(0, 7));
        i_st_addr   = 32'h4000 + $urandom_range(0, 31);
        i_st_data   = $urandom;
        i_mem_ready = ($urandom_range(0, 9) < 6);
        i_fwd_addr  = 32'h4000 + $urandom_range(0, 31);
        #1;
        hz = 1'b0;
        foreach (mq[j]) if (mq[j].word == i_fwd_addr[31:2]) hz = 1'b1;
        chk("rnd_count", 32'(o_count), 32'(mq.size()));
        chk("rnd_ready", 32'(o_st_ready), 32'(mq.size() < 4));
        chk("rnd_empty", 32'(o_empty), 32'(mq.size() == 0));
        chk("rnd_err", 32'(o_st_err), 32'(m_err));
        chk("rnd_hazard", 32'(o_fwd_hazard), 32'(hz));
        if (mq.size() > 0) begin
          chk("rnd_head_addr", o_mem_addr, {mq[0].word, 2'b00});
          chk("rnd_head_wdata", o_mem_wdata, mq[0].wdata);
          chk("rnd_head_bmask", 32'(o_mem_bmask), 32'(mq[0].bmask));
        end else begin
          chk("rnd_valid", 32'(o_mem_valid), 32'd0);
        end
        model_align(i_st_addr, i_st_data, i_sl_sel, bad, wd, bm);
        if (i_reset) begin
          mq.delete();
          m_err = 1'b0;
        end else begin
          accept = i_st_valid && (mq.size() < 4);
          m_err  = accept && bad;
          if (mq.size() > 0 && i_mem_ready) void'(mq.pop_front());
          if (accept && !bad) begin
            e.word = i_st_addr[31:2]; e.wdata = wd; e.bmask = bm;
            mq.push_back(e);
          end
        end
        tick();
      end
    end
    i_reset = 1'b0;
    i_st_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
